key_event_array: RTL and testbench

- Multi-channel successor to the single-key click detector.
- Each of N_KEYS raw key inputs gets a 2-FF synchroniser and a debouncer.
- A per-channel state machine produces a debounced level plus single-cycle press (click), release, long-press and auto-repeat pulses.
- Sits between board push-buttons and the control FSMs of the experiment designs; replaces per-key instances of the old click detector.

---
 rtl/key_event_array_pkg.sv | 27 ++
 rtl/key_event_channel.sv | 154 +++++++++++++++
 rtl/key_event_array.sv | 48 ++++
 tb/tb_key_event_array.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/key_event_array_pkg.sv
// +----------------------------------------------------------------------------+
// | key_event_array_pkg : FSM encodings and width helper for key_event_array   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package key_event_array_pkg;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HELD = 2'd1;
    localparam logic [1:0] c_ST_LONG = 2'd2;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << w) < 64'(value)) begin
                w = w + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_event_channel.sv
// +----------------------------------------------------------------------------+
// | key_event_channel : synchroniser, debouncer, event FSM for one key         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module key_event_channel
    import key_event_array_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int REPEAT_EN       = 1,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic pressed_o,
    output logic click_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o
);

    localparam int c_DB_W     = clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int c_HOLD_W   = clog2(c_HOLD_MAX + 1);

    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DB_W-1:0]   c_DB_ONE    = c_DB_W'(1);
    localparam logic [c_HOLD_W-1:0] c_LONG_LAST = c_HOLD_W'(LONG_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_REP_LAST  = c_HOLD_W'(REPEAT_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
    localparam logic                c_INV       = (ACTIVE_LOW != 0);
    localparam logic                c_REP_EN    = (REPEAT_EN != 0);

    logic                r_s1;
    logic                r_s2;
    logic                r_stable;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic [1:0]          r_state;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_click;
    logic                r_release;
    logic                r_long;
    logic                r_repeat;

    logic                w_flip;
    logic                w_rise;
    logic                w_fall;
    logic [1:0]          w_state_nxt;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic                w_click;
    logic                w_release;
    logic                w_long;
    logic                w_repeat;

    assign w_flip = (r_s2 != r_stable) && (r_db_cnt == c_DB_LAST);
    assign w_rise = w_flip && !r_stable;
    assign w_fall = w_flip && r_stable;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // s1 holds the raw idle level so an active-low key does not glitch out of reset
            r_s1       <= c_INV;
            r_s2       <= 1'b0;
            r_stable   <= 1'b0;
            r_db_cnt   <= '0;
            r_state    <= c_ST_IDLE;
            r_hold_cnt <= '0;
            r_click    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
            r_repeat   <= 1'b0;
        end else begin
            r_s1 <= key_i;
            r_s2 <= r_s1 ^ c_INV;
            if (r_s2 != r_stable) begin
                if (r_db_cnt == c_DB_LAST) begin
                    r_stable <= ~r_stable;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + c_DB_ONE;
                end
            end else begin
                r_db_cnt <= '0;
            end
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_click    <= w_click;
            r_release  <= w_release;
            r_long     <= w_long;
            r_repeat   <= w_repeat;
        end
    end

    // A debounced release takes priority over any hold threshold in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_click     = 1'b0;
        w_release   = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;
        if (w_fall) begin
            w_state_nxt = c_ST_IDLE;
            w_hold_nxt  = '0;
            w_release   = 1'b1;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_rise) begin
                        w_state_nxt = c_ST_HELD;
                        w_hold_nxt  = '0;
                        w_click     = 1'b1;
                    end
                end
                c_ST_HELD: begin
                    if (r_hold_cnt == c_LONG_LAST) begin
                        w_state_nxt = c_ST_LONG;
                        w_hold_nxt  = '0;
                        w_long      = 1'b1;
                    end else begin
                        w_hold_nxt = r_hold_cnt + c_HOLD_ONE;
                    end
                end
                c_ST_LONG: begin
                    if (!c_REP_EN) begin
                        w_hold_nxt = '0;
                    end else if (r_hold_cnt == c_REP_LAST) begin
                        w_hold_nxt = '0;
                        w_repeat   = 1'b1;
                    end else begin
                        w_hold_nxt = r_hold_cnt + c_HOLD_ONE;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                    w_hold_nxt  = '0;
                end
            endcase
        end
    end

    assign pressed_o = r_stable;
    assign click_o   = r_click;
    assign release_o = r_release;
    assign long_o    = r_long;
    assign repeat_o  = r_repeat;

endmodule

`default_nettype wire

// File: rtl/key_event_array.sv
// +----------------------------------------------------------------------------+
// | key_event_array : N independent debounced key channels with event pulses  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module key_event_array
    import key_event_array_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int REPEAT_EN       = 1,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_KEYS-1:0] key_i,
    output logic [N_KEYS-1:0] pressed_o,
    output logic [N_KEYS-1:0] click_o,
    output logic [N_KEYS-1:0] release_o,
    output logic [N_KEYS-1:0] long_o,
    output logic [N_KEYS-1:0] repeat_o
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_event_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .key_i     (key_i[g]),
            .pressed_o (pressed_o[g]),
            .click_o   (click_o[g]),
            .release_o (release_o[g]),
            .long_o    (long_o[g]),
            .repeat_o  (repeat_o[g])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_key_event_array.sv
// +----------------------------------------------------------------------------+
// | tb_key_event_array : random and directed key stimulus vs behavioural model |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_key_event_array;

    localparam int N  = 2;
    localparam int DB = 4;
    localparam int LG = 10;
    localparam int RP = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] key = '0;
    logic [N-1:0] key_n;

    logic [N-1:0] pa, ca, ra, la, rpa;
    logic [N-1:0] pb, cb, rb, lb, rpb;

    assign key_n = ~key;

    always #5 clk = ~clk;

    // Instance a: active-high keys with repeat; instance b: active-low keys, no repeat.
    key_event_array #(
        .N_KEYS(N), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG),
        .REPEAT_CYCLES(RP), .REPEAT_EN(1), .ACTIVE_LOW(0)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .key_i(key),
        .pressed_o(pa), .click_o(ca), .release_o(ra), .long_o(la), .repeat_o(rpa)
    );

    key_event_array #(
        .N_KEYS(N), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG),
        .REPEAT_CYCLES(RP), .REPEAT_EN(0), .ACTIVE_LOW(1)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .key_i(key_n),
        .pressed_o(pb), .click_o(cb), .release_o(rb), .long_o(lb), .repeat_o(rpb)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state per instance/channel, in the key's active sense.
    bit           m_s1   [2][N];
    bit           m_s2   [2][N];
    bit           m_stab [2][N];
    int           m_run  [2][N];
    int           m_held [2][N];
    logic [N-1:0] e_p [2];
    logic [N-1:0] e_c [2];
    logic [N-1:0] e_r [2];
    logic [N-1:0] e_l [2];
    logic [N-1:0] e_rp[2];

    task automatic model_step(input logic r, input logic [N-1:0] k);
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < N; c++) begin
                bit rise;
                bit fall;
                rise = 1'b0;
                fall = 1'b0;
                e_c[i][c]  = 1'b0;
                e_r[i][c]  = 1'b0;
                e_l[i][c]  = 1'b0;
                e_rp[i][c] = 1'b0;
                if (r) begin
                    m_s1[i][c] = 0; m_s2[i][c] = 0; m_stab[i][c] = 0;
                    m_run[i][c] = 0; m_held[i][c] = 0;
                end else begin
                    // sample must differ from the stable level for DB consecutive edges
                    if (m_s2[i][c] != m_stab[i][c]) begin
                        m_run[i][c]++;
                        if (m_run[i][c] == DB) begin
                            m_stab[i][c] = !m_stab[i][c];
                            m_run[i][c]  = 0;
                            rise = m_stab[i][c];
                            fall = !m_stab[i][c];
                        end
                    end else begin
                        m_run[i][c] = 0;
                    end
                    if (rise) begin
                        e_c[i][c] = 1'b1;
                        m_held[i][c] = 0;
                    end else if (fall) begin
                        e_r[i][c] = 1'b1;
                    end else if (m_stab[i][c]) begin
                        m_held[i][c]++;
                        if (m_held[i][c] == LG)
                            e_l[i][c] = 1'b1;
                        else if (i == 0 && m_held[i][c] > LG && ((m_held[i][c] - LG) % RP) == 0)
                            e_rp[i][c] = 1'b1;
                    end
                    m_s2[i][c] = m_s1[i][c];
                    m_s1[i][c] = k[c];
                end
                e_p[i][c] = m_stab[i][c];
            end
        end
    endtask

    task automatic tick(input logic r, input logic [N-1:0] k);
        rst = r;
        key = k;
        @(posedge clk);
        model_step(r, k);
        #1;
        check("pressed_a", pa,  e_p[0]);
        check("click_a",   ca,  e_c[0]);
        check("release_a", ra,  e_r[0]);
        check("long_a",    la,  e_l[0]);
        check("repeat_a",  rpa, e_rp[0]);
        check("pressed_b", pb,  e_p[1]);
        check("click_b",   cb,  e_c[1]);
        check("release_b", rb,  e_r[1]);
        check("long_b",    lb,  e_l[1]);
        check("repeat_b",  rpb, e_rp[1]);
    endtask

    initial begin
        int           rem [N];
        logic [N-1:0] kv;

        repeat (2) tick(1'b1, 2'b00);
        repeat (3) tick(1'b0, 2'b00);

        // Clean press into long and repeats, then release
        repeat (30) tick(1'b0, 2'b01);
        repeat (12) tick(1'b0, 2'b00);

        // Bounce rejection on key 1
        repeat (5) begin
            repeat (3) tick(1'b0, 2'b10);
            repeat (2) tick(1'b0, 2'b00);
        end
        repeat (8) tick(1'b0, 2'b00);

        // Release racing the long threshold
        repeat (10) tick(1'b0, 2'b01);
        repeat (12) tick(1'b0, 2'b00);

        // Reset mid-hold with key still held
        repeat (12) tick(1'b0, 2'b01);
        tick(1'b1, 2'b01);
        repeat (10) tick(1'b0, 2'b01);
        repeat (8) tick(1'b0, 2'b00);

        // Both channels together
        repeat (20) tick(1'b0, 2'b11);
        repeat (8) tick(1'b0, 2'b00);

        // Randomised holds and bounces with occasional reset
        kv = '0;
        for (int c = 0; c < N; c++) rem[c] = $urandom_range(1, 20);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (rem[c] == 0) begin
                    kv[c]  = ~kv[c];
                    rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 40);
                end
                rem[c]--;
            end
            tick(($urandom_range(0, 499) == 0), kv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
